// File: rtl/mem_unloader_if.sv
// mem_unloader_if: bundles the data-memory read port and the output word stream of the
// memory unloader.
//   master (unloader side): drives mem_rd_en/mem_rd_addr, receives mem_rd_data;
//                           drives out_valid/out_data/out_last, receives out_ready.
//   slave  (memory + sink): the mirror image.
// Parameters must match the attached mem_unloader (NUM_SIZE, ADDR_W = clog2(BUFFER_LEN)).
interface mem_unloader_if #(
  parameter int unsigned NUM_SIZE = 16,
  parameter int unsigned ADDR_W   = 5
);
  logic                mem_rd_en;
  logic [ADDR_W-1:0]   mem_rd_addr;
  logic [NUM_SIZE-1:0] mem_rd_data;
  logic                out_valid;
  logic                out_ready;
  logic [NUM_SIZE-1:0] out_data;
  logic                out_last;

  modport master (
    output mem_rd_en,
    output mem_rd_addr,
    input  mem_rd_data,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_last
  );

  modport slave (
    input  mem_rd_en,
    input  mem_rd_addr,
    output mem_rd_data,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_last
  );
endinterface

// File: rtl/mem_unloader.sv
// mem_unloader: reads a contiguous (wrapping) window of the accelerator data memory through a
// synchronous read port and streams the words out on a valid/ready interface.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   start      one-cycle launch request, sampled in IDLE only
//   base_addr  first word address, sampled with start
//   count      number of words (clamped to BUFFER_LEN), sampled with start
//   busy       high while an unload is in progress (including the DONE cycle)
//   done       one-cycle completion pulse
//   bus        mem_unloader_if.master: memory read port + output stream
//
// Optional build macro MEM_UNLOADER_CHECKSUM_EN: append one word holding the sum of all streamed
// words (mod 2^NUM_SIZE); out_last then marks that checksum word.
//
// Reads return one cycle after mem_rd_en and land in a 2-entry FIFO the following edge. A read
// is issued only while FIFO occupancy + returning read - this cycle's pop stays below 2, which
// keeps the FIFO from overflowing and still sustains one word per cycle with out_ready high.
module mem_unloader #(
  parameter int unsigned  NUM_SIZE   = 16,
  parameter int unsigned  BUFFER_LEN = 32,
  localparam int unsigned ADDR_W     = $clog2(BUFFER_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  mem_unloader_if.master    bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  localparam logic [ADDR_W:0] MaxCount = (ADDR_W + 1)'(BUFFER_LEN);
  localparam logic [ADDR_W:0] CntOne   = (ADDR_W + 1)'(1);

  state_e              state_q;
  logic                busy_q;
  logic                done_q;
  logic                primed_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W:0]     issue_rem_q;
  logic [ADDR_W:0]     push_rem_q;
  logic                rdv_q;        // read issued last cycle: mem_rd_data valid now
  logic [NUM_SIZE-1:0] fifo_data_q [2];
  logic [1:0]          fifo_last_q;
  logic                wr_ptr_q;
  logic                rd_ptr_q;
  logic [1:0]          fifo_cnt_q;
`ifdef MEM_UNLOADER_CHECKSUM_EN
  logic [NUM_SIZE-1:0] sum_q;
  logic                ck_pend_q;
  logic                ck_push;
`endif

  logic                pop;
  logic                issue;
  logic [2:0]          credit;
  logic                push;
  logic [NUM_SIZE-1:0] push_data;
  logic                push_last;
  logic [ADDR_W:0]     count_clamped;

  always_comb begin
    count_clamped = (count > MaxCount) ? MaxCount : count;

    pop    = (fifo_cnt_q != 2'd0) && bus.out_ready;
    // Words held or on their way into the FIFO after this edge, before any new read.
    credit = {1'b0, fifo_cnt_q} + {2'b00, rdv_q} - {2'b00, pop};
    // The first RUN cycle only loads the window; reads start on the cycle after.
    issue  = (state_q == StRun) && primed_q && (credit < 3'd2);

    push      = rdv_q;
    push_data = bus.mem_rd_data;
`ifdef MEM_UNLOADER_CHECKSUM_EN
    push_last = 1'b0;
    // Checksum goes in once every data word has entered the FIFO.
    ck_push   = (state_q == StDrain) && ck_pend_q && (push_rem_q == '0) && !rdv_q &&
                (fifo_cnt_q != 2'd2);
    if (ck_push) begin
      push      = 1'b1;
      push_data = sum_q;
      push_last = 1'b1;
    end
`else
    push_last = (push_rem_q == CntOne);
`endif
  end

  assign bus.mem_rd_en   = issue;
  assign bus.mem_rd_addr = addr_q;
  assign bus.out_valid   = (fifo_cnt_q != 2'd0);
  assign bus.out_data    = fifo_data_q[rd_ptr_q];
  assign bus.out_last    = (fifo_cnt_q != 2'd0) && fifo_last_q[rd_ptr_q];
  assign busy            = busy_q;
  assign done            = done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StIdle;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      primed_q       <= 1'b0;
      addr_q         <= '0;
      issue_rem_q    <= '0;
      push_rem_q     <= '0;
      rdv_q          <= 1'b0;
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_last_q    <= '0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      fifo_cnt_q     <= 2'd0;
`ifdef MEM_UNLOADER_CHECKSUM_EN
      sum_q          <= '0;
      ck_pend_q      <= 1'b0;
`endif
    end else begin
      rdv_q <= issue;

      if (push) begin
        fifo_data_q[wr_ptr_q] <= push_data;
        fifo_last_q[wr_ptr_q] <= push_last;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      fifo_cnt_q <= fifo_cnt_q + {1'b0, push} - {1'b0, pop};

      if (rdv_q) begin
        push_rem_q <= push_rem_q - CntOne;
      end
`ifdef MEM_UNLOADER_CHECKSUM_EN
      if (rdv_q) begin
        sum_q <= sum_q + bus.mem_rd_data;
      end
      if (ck_push) begin
        ck_pend_q <= 1'b0;
      end
`endif

      unique case (state_q)
        StIdle: begin
          if (start) begin
            busy_q      <= 1'b1;
            primed_q    <= 1'b0;
            addr_q      <= base_addr;
            issue_rem_q <= count_clamped;
            push_rem_q  <= count_clamped;
`ifdef MEM_UNLOADER_CHECKSUM_EN
            sum_q     <= '0;
            ck_pend_q <= 1'b1;
            // Zero words still emit the checksum, so skip straight to draining it.
            state_q   <= (count_clamped == '0) ? StDrain : StRun;
`else
            if (count_clamped == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StRun;
            end
`endif
          end
        end
        StRun: begin
          primed_q <= 1'b1;
          if (issue) begin
            addr_q      <= addr_q + 1'b1;  // power-of-two buffer: wraps naturally
            issue_rem_q <= issue_rem_q - CntOne;
            if (issue_rem_q == CntOne) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if (pop && fifo_last_q[rd_ptr_q]) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
